pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 106 ++++++++++
 tb/tb_pc_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit with a two-state RUN/EXC machine.
// Next-PC selection, exception entry/return, address checking and a retire counter.
module pc_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IM_AW      = 11,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       imm16,
  input  logic              jump,
  input  logic [25:0]       idx26,
  input  logic              jr,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              exc_req,
  input  logic              eret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [IM_AW-1:0]  im_addr,
  output logic [ADDR_W-1:0] epc,
  output logic              in_exc,
  output logic              addr_err,
  output logic [31:0]       retired
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_EXC = 1'b1;

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(TEXT_BASE);
  localparam logic [ADDR_W-1:0] VECTOR_A = ADDR_W'(EXC_VECTOR);
  // Range bounds carry one extra bit so the upper limit cannot wrap.
  localparam logic [ADDR_W:0]   RANGE_LO = (ADDR_W+1)'(TEXT_BASE);
  localparam logic [ADDR_W:0]   RANGE_HI = RANGE_LO + ((ADDR_W+1)'(1) << (IM_AW + 2));

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] epc_r;
  logic [0:0]        state_r;
  logic [31:0]       retired_r;

  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] next_epc_s;
  logic [0:0]        next_state_s;
  logic              load_s;
  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] jump_tgt_s;
  logic [ADDR_W-1:0] diff_s;

  assign pc_plus4   = pc_r + ADDR_W'(4);
  assign br_off_s   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  assign jump_tgt_s = (pc_plus4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({idx26, 2'b00});
  assign diff_s     = pc_r - BASE_A;
  assign im_addr    = IM_AW'(diff_s >> 2);
  assign addr_err   = (pc_r[1:0] != 2'b00) ||
                      ({1'b0, pc_r} < RANGE_LO) ||
                      ({1'b0, pc_r} >= RANGE_HI);

  assign pc      = pc_r;
  assign epc     = epc_r;
  assign in_exc  = (state_r == ST_EXC);
  assign retired = retired_r;

  // Next-state selection in priority order; stall is the only rule that does not load the PC.
  always_comb begin
    next_pc_s    = pc_r;
    next_epc_s   = epc_r;
    next_state_s = state_r;
    load_s       = 1'b1;
    if ((state_r == ST_RUN) && exc_req) begin
      next_pc_s    = VECTOR_A;
      next_epc_s   = pc_r;
      next_state_s = ST_EXC;
    end else if ((state_r == ST_EXC) && eret) begin
      next_pc_s    = epc_r;
      next_state_s = ST_RUN;
    end else if (stall) begin
      load_s = 1'b0;
    end else if (jr) begin
      next_pc_s = rs_val;
    end else if (jump) begin
      next_pc_s = jump_tgt_s;
    end else if (br_taken) begin
      next_pc_s = pc_plus4 + br_off_s;
    end else begin
      next_pc_s = pc_plus4;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= BASE_A;
      epc_r     <= '0;
      state_r   <= ST_RUN;
      retired_r <= 32'd0;
    end else begin
      pc_r      <= next_pc_s;
      epc_r     <= next_epc_s;
      state_r   <= next_state_s;
      retired_r <= retired_r + {31'd0, load_s};
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the PC rules.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [15:0] imm16;
  logic        jump;
  logic [25:0] idx26;
  logic        jr;
  logic [31:0] rs_val;
  logic        exc_req;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [10:0] im_addr;
  logic [31:0] epc;
  logic        in_exc;
  logic        addr_err;
  logic [31:0] retired;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_exc;
  logic [31:0] m_ret;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .imm16(imm16), .jump(jump), .idx26(idx26), .jr(jr), .rs_val(rs_val),
    .exc_req(exc_req), .eret(eret), .pc(pc), .pc_plus4(pc_plus4),
    .im_addr(im_addr), .epc(epc), .in_exc(in_exc), .addr_err(addr_err),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently applied inputs.
  task automatic model_step();
    logic moved;
    moved = 1'b1;
    if (reset) begin
      m_pc = 32'h0000_3000; m_epc = 32'd0; m_exc = 1'b0; m_ret = 32'd0;
    end else begin
      if (!m_exc && exc_req) begin
        m_epc = m_pc; m_pc = 32'h0000_4180; m_exc = 1'b1;
      end else if (m_exc && eret) begin
        m_pc = m_epc; m_exc = 1'b0;
      end else if (stall) begin
        moved = 1'b0;
      end else if (jr) begin
        m_pc = rs_val;
      end else if (jump) begin
        m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(idx26) * 32'd4);
      end else if (br_taken) begin
        m_pc = m_pc + 32'd4 + (32'($signed(imm16)) * 32'd4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
      if (moved) m_ret = m_ret + 32'd1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_im;
    logic        exp_err;
    exp_im  = ((m_pc - 32'h0000_3000) / 32'd4) % 32'd2048;
    exp_err = (m_pc % 32'd4 != 32'd0) || (m_pc < 32'h0000_3000) || (m_pc >= 32'h0000_5000);
    cmp({tag, ".pc"},       pc,                m_pc);
    cmp({tag, ".pc_plus4"}, pc_plus4,          m_pc + 32'd4);
    cmp({tag, ".im_addr"},  32'(im_addr),      exp_im);
    cmp({tag, ".epc"},      epc,               m_epc);
    cmp({tag, ".in_exc"},   32'(in_exc),       32'(m_exc));
    cmp({tag, ".addr_err"}, 32'(addr_err),     32'(exp_err));
    cmp({tag, ".retired"},  retired,           m_ret);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; imm16 = 16'd0; jump = 1'b0;
    idx26 = 26'd0; jr = 1'b0; rs_val = 32'd0; exc_req = 1'b0; eret = 1'b0;
  endtask

  task automatic go_jr(input logic [31:0] target, input string tag);
    idle(); jr = 1'b1; rs_val = target; tick(tag); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    m_pc = 32'd0; m_epc = 32'd0; m_exc = 1'b0; m_ret = 32'd0;
    idle();
    @(negedge clk);

    // Reset, including reset with competing requests high
    reset = 1'b1; tick("reset");
    exc_req = 1'b1; stall = 1'b1; eret = 1'b1; tick("reset_busy");
    cmp("reset_pc_const", pc, 32'h0000_3000);
    cmp("reset_epc_const", epc, 32'd0);
    idle();

    // Three sequential cycles
    tick("seq1"); tick("seq2"); tick("seq3");
    cmp("seq_pc_const", pc, 32'h0000_300C);
    cmp("seq_im_const", 32'(im_addr), 32'd3);
    cmp("seq_ret_const", retired, 32'd3);

    // Backward branch and jump from 0x3010
    tick("to_3010");
    br_taken = 1'b1; imm16 = 16'hFFFE; tick("branch_back");
    cmp("branch_const", pc, 32'h0000_300C);
    idle(); tick("to_3010b");
    jump = 1'b1; idx26 = 26'h000_0C10; tick("jump");
    cmp("jump_const", pc, 32'h0000_3040);
    idle();

    // Stall holds a pending jr
    go_jr(32'h0000_3008, "jr_3008");
    stall = 1'b1; jr = 1'b1; rs_val = 32'h0000_3100;
    tick("stall1"); tick("stall2");
    cmp("stall_pc_const", pc, 32'h0000_3008);
    stall = 1'b0; tick("stall_release");
    cmp("stall_release_const", pc, 32'h0000_3100);
    idle();

    // Exception entry under stall, repeated request, return
    go_jr(32'h0000_3020, "jr_3020");
    exc_req = 1'b1; stall = 1'b1; tick("exc_enter");
    cmp("exc_pc_const", pc, 32'h0000_4180);
    cmp("exc_epc_const", epc, 32'h0000_3020);
    stall = 1'b0; tick("exc_again");
    cmp("exc_again_epc_const", epc, 32'h0000_3020);
    idle(); eret = 1'b1; tick("eret");
    cmp("eret_pc_const", pc, 32'h0000_3020);
    idle();

    // Address error cases and wraparound
    go_jr(32'h0000_3002, "jr_misaligned");
    cmp("misaligned_const", 32'(addr_err), 32'd1);
    go_jr(32'h0000_2FFC, "jr_below");
    cmp("below_const", 32'(addr_err), 32'd1);
    go_jr(32'h0000_4FFC, "jr_top");
    tick("past_top");
    go_jr(32'hFFFF_FFFC, "jr_max");
    tick("wrap");
    cmp("wrap_const", pc, 32'h0000_0000);

    // eret beats exc_req in EXC; reset wins in EXC
    go_jr(32'h0000_3100, "jr_3100");
    exc_req = 1'b1; tick("exc2_enter");
    eret = 1'b1; tick("exc_eret_both");
    cmp("both_pc_const", pc, 32'h0000_3100);
    idle(); exc_req = 1'b1; tick("exc3_enter");
    reset = 1'b1; eret = 1'b1; stall = 1'b1; tick("reset_in_exc");
    cmp("rst_exc_const", 32'(in_exc), 32'd0);
    cmp("rst_ret_const", retired, 32'd0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      exc_req  = ($urandom_range(0, 9) == 0);
      eret     = ($urandom_range(0, 5) == 0);
      jr       = ($urandom_range(0, 7) == 0);
      jump     = ($urandom_range(0, 9) == 0);
      br_taken = ($urandom_range(0, 3) == 0);
      imm16    = 16'($urandom);
      idx26    = 26'($urandom);
      rs_val   = ($urandom_range(0, 3) == 0) ? $urandom
                                             : 32'h0000_3000 + 32'($urandom_range(0, 2047)) * 32'd4;
      tick("rand");
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
